// File: rtl/counterdown_loader.sv
// counterdown_loader: loadable binary down counter with count enable,
// a registered terminal-count pulse, and one-shot / auto-reload modes.
// Serves as a programmable interval timer or delay generator.
//
// Optional build macro PRESCALE_EN: when defined, a prescaler divides the
// enabled cycles by PSC_DIV so the counter ticks once per PSC_DIV enabled
// cycles. When undefined, every enabled cycle in RUN is a tick and PSC_DIV
// has no effect.
module counterdown_loader #(
  parameter int WIDTH   = 4,
  parameter int PSC_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cntr,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cntr_q, cntr_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             tick;

`ifdef PRESCALE_EN
  localparam int PSC_W = (PSC_DIV > 1) ? $clog2(PSC_DIV) : 1;

  logic [PSC_W-1:0] psc_q, psc_d;

  // Prescaler next state: cleared by load, advances on enabled cycles and
  // produces a tick on the enabled cycle where it wraps back to zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    psc_d = psc_q;
    tick  = 1'b0;
    if (load) begin
      psc_d = '0;
    end else if (en) begin
      if (psc_q == PSC_W'(PSC_DIV - 1)) begin
        psc_d = '0;
        tick  = 1'b1;
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) psc_q <= '0;
    else     psc_q <= psc_d;
  end
`else
  // Without a prescaler every enabled cycle is a tick.
  always_comb begin
    tick = en;
  end
`endif

  // State register; reset wins over load and tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the values from before the edge, independent of
    // statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: load restarts (or idles on a zero load); a one-shot
  // count finishing moves to DONE.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (din != '0) ? RUN : IDLE;
    end else if (state_q == RUN && tick && !auto_reload
                 && cntr_q <= WIDTH'(1)) begin
      // Covers the 1->0 edge in one-shot mode, and also a counter parked
      // at 0 in RUN after auto_reload was dropped: both end the count.
      state_d = DONE;
    end
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next state: load, decrement, or reload; tc only on 1->0.
  always_comb begin
    cntr_d   = cntr_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      cntr_d   = din;
      reload_d = din;
    end else if (state_q == RUN && tick) begin
      if (cntr_q != '0) begin
        cntr_d = cntr_q - WIDTH'(1);
        tc_d   = (cntr_q == WIDTH'(1));
      end else if (auto_reload) begin
        cntr_d = reload_q;
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cntr_q   <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      cntr_q   <= cntr_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign cntr = cntr_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_counterdown_loader.sv
// Self-checking bench for counterdown_loader: a table of directed vectors
// (inputs plus hand-computed outputs after the next rising edge), followed
// by hand-written one-shot and prescaler sequences.
module tb_counterdown_loader;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] cntr;
  logic             tc;
  logic             busy;
  logic             done;

  int n_cmp  = 0;
  int n_fail = 0;

  counterdown_loader #(.WIDTH(WIDTH), .PSC_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .din         (din),
    .en          (en),
    .auto_reload (auto_reload),
    .cntr        (cntr),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             en;
    logic             ar;
    logic [WIDTH-1:0] e_cntr;
    logic             e_tc;
    logic             e_busy;
    logic             e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic add(input logic r, input logic l, input int d, input logic e,
                     input logic a, input int c, input logic t,
                     input logic b, input logic dn);
    vec_t v;
    v.rst = r; v.load = l; v.din = WIDTH'(d); v.en = e; v.ar = a;
    v.e_cntr = WIDTH'(c); v.e_tc = t; v.e_busy = b; v.e_done = dn;
    vecs.push_back(v);
  endtask

  // Apply inputs, clock once, sample #1 after the edge.
  task automatic step(input logic r, input logic l, input int d,
                      input logic e, input logic a);
    rst = r; load = l; din = WIDTH'(d); en = e; auto_reload = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input logic t,
                           input logic b, input logic dn);
    check({tag, ".cntr"}, int'(cntr), c);
    check({tag, ".tc"},   int'(tc),   int'(t));
    check({tag, ".busy"}, int'(busy), int'(b));
    check({tag, ".done"}, int'(done), int'(dn));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din = '0; en = 1'b0; auto_reload = 1'b0;

    //    rst load din en ar | cntr tc busy done
    // Reset dominates load.
    add(1, 1, 9,  0, 0,  0, 0, 0, 0);
    add(1, 1, 9,  0, 0,  0, 0, 0, 0);
`ifndef PRESCALE_EN
    // Auto-reload, din=3: 3,2,1,0,3,2,1,0,3,2,1,0 with tc at each 0.
    add(0, 1, 3,  0, 1,  3, 0, 1, 0);
    for (int k = 0; k < 11; k++) begin
      int c;
      c = 2 - (k % 4);
      if (c < 0) c = 3;
      add(0, 0, 0, 1, 1, c, (c == 0), 1, 0);
    end
    // Enable gap, reload during RUN, load of zero.
    add(0, 1, 9,  0, 0,  9, 0, 1, 0);
    add(0, 0, 0,  1, 0,  8, 0, 1, 0);
    add(0, 0, 0,  1, 0,  7, 0, 1, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 7, 0, 1, 0);
    add(0, 0, 0,  1, 0,  6, 0, 1, 0);
    add(0, 0, 0,  1, 0,  5, 0, 1, 0);
    add(0, 1, 9,  1, 0,  9, 0, 1, 0);
    add(0, 0, 0,  1, 0,  8, 0, 1, 0);
    add(0, 1, 0,  1, 0,  0, 0, 0, 0);
    add(0, 0, 0,  1, 1,  0, 0, 0, 0);
    add(0, 0, 0,  1, 0,  0, 0, 0, 0);
    // Reset mid-count beats a simultaneous load.
    add(0, 1, 4,  0, 0,  4, 0, 1, 0);
    add(1, 1, 12, 1, 0,  0, 0, 0, 0);
    add(0, 0, 0,  1, 0,  0, 0, 0, 0);
    // Load beats tick; one-shot from 1 ends in DONE with a single tc.
    add(0, 1, 1,  1, 0,  1, 0, 1, 0);
    add(0, 0, 0,  1, 0,  0, 1, 0, 1);
    add(0, 0, 0,  1, 1,  0, 0, 0, 1);
    // Maximum load value decrements without wrapping.
    add(0, 1, 15, 1, 1, 15, 0, 1, 0);
    add(0, 0, 0,  1, 1, 14, 0, 1, 0);
    // Auto-reload with din=1: 1,0,1,0.
    add(0, 1, 1,  0, 1,  1, 0, 1, 0);
    add(0, 0, 0,  1, 1,  0, 1, 1, 0);
    add(0, 0, 0,  1, 1,  1, 0, 1, 0);
    add(0, 0, 0,  1, 1,  0, 1, 1, 0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].din, vecs[i].en, vecs[i].ar);
      check_all($sformatf("vec%0d", i), int'(vecs[i].e_cntr), vecs[i].e_tc,
                vecs[i].e_busy, vecs[i].e_done);
    end

`ifndef PRESCALE_EN
    // One-shot from 13: 13..0, tc only at 0, then DONE holds for 20 cycles.
    step(0, 1, 13, 0, 0);
    check_all("os_load", 13, 0, 1, 0);
    for (int k = 12; k >= 0; k--) begin
      step(0, 0, 0, 1, 0);
      check_all($sformatf("os_%0d", k), k, (k == 0), (k != 0), (k == 0));
    end
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 1, 0);
      check_all($sformatf("os_hold%0d", k), 0, 0, 0, 1);
    end
`else
    // Prescaled by 4: din=2 changes every 4 enabled cycles, single tc at 0.
    step(0, 1, 2, 0, 0);
    check_all("psc_load", 2, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (k < 4) ? 2 : (k < 8) ? 1 : 0;
      step(0, 0, 0, 1, 0);
      check_all($sformatf("psc_%0d", k), c, (k == 8), (k != 8), (k == 8));
    end
    step(0, 0, 0, 1, 0);
    check_all("psc_after", 0, 0, 0, 1);
    // Prescaler holds while en=0: 3 enabled, gap, 1 more ticks once.
    step(0, 1, 3, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);
    check("psc_gap_pre", int'(cntr), 3);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    check("psc_gap_hold", int'(cntr), 3);
    step(0, 0, 0, 1, 0);
    check("psc_gap_tick", int'(cntr), 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
